pll_lock_sequencer: RTL and testbench

Sequences reset and lock qualification for the board PLL (125 MHz reference → 40/160 MHz outputs). Runs on the PLL reference clock and drives the PLL reset input. It watches the PLL `locked` flag, retries bounded failed lock attempts, and raises a single qualified `clk_ready` that gates release of downstream resets in the 40/160 MHz domains. After a lock loss it re-sequences automatically; a relock request restarts the sequence on demand.

---
 rtl/pll_seq_pkg.sv | 30 +++
 rtl/sync_2ff.sv | 30 +++
 rtl/pll_lock_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
//
// Contents:
//   pll_state_e     - 3-bit sequencer state, encodings exposed on the status port
//   Def*            - default values for the sequencer parameters
//   LossCountWidth  - width of the lock-loss counter port
//   cnt_width()     - counter width helper that never returns zero
package pll_seq_pkg;

  typedef enum logic [2:0] {
    StResetPll  = 3'd0,
    StWaitLock  = 3'd1,
    StStabilize = 3'd2,
    StReady     = 3'd3,
    StFault     = 3'd4
  } pll_state_e;

  localparam int unsigned DefResetCycles = 16;
  localparam int unsigned DefLockTimeout = 125000;
  localparam int unsigned DefLockStable  = 1024;
  localparam int unsigned DefMaxRetries  = 4;

  localparam int unsigned LossCountWidth = 8;

  // $clog2 of a terminal count; a count of 1 still needs a 1-bit register.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
//
// Ports:
//   clk_i - destination clock
//   rst_i - synchronous active-high reset, clears both flops
//   d_i   - asynchronous input
//   q_o   - input resynchronised to clk_i, two cycles of latency
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock qualification sequencer.
//
// Holds the PLL in reset, waits for a synchronised lock, requires the lock to be
// stable for LOCK_STABLE cycles before raising clk_ready, and retries failed
// attempts up to MAX_RETRIES times before parking in a fault state. A lock loss
// in READY re-sequences automatically; relock_req restarts from READY or FAULT.
//
// Ports:
//   refclk      - PLL reference clock, the only clock
//   rst         - synchronous active-high reset
//   pll_locked  - asynchronous PLL locked flag
//   relock_req  - single-cycle restart request (READY / FAULT only)
//   pll_rst     - PLL reset output
//   clk_ready   - PLL outputs qualified
//   fault       - retries exhausted
//   retry_count - failed attempts in the current sequence
//   state       - current state encoding
//   loss_count  - lock losses seen in READY
//
// Build option: define PLL_SEQ_LOSS_COUNT_EN to include the saturating lock-loss
// counter; otherwise loss_count is tied to zero.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = DefResetCycles,
  parameter int unsigned LOCK_TIMEOUT = DefLockTimeout,
  parameter int unsigned LOCK_STABLE  = DefLockStable,
  parameter int unsigned MAX_RETRIES  = DefMaxRetries
) (
  input  logic                              refclk,
  input  logic                              rst,
  input  logic                              pll_locked,
  input  logic                              relock_req,
  output logic                              pll_rst,
  output logic                              clk_ready,
  output logic                              fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]  retry_count,
  output logic [2:0]                        state,
  output logic [LossCountWidth-1:0]         loss_count
);

  localparam int unsigned RstW    = cnt_width(RESET_CYCLES);
  localparam int unsigned TimerW  = cnt_width(LOCK_TIMEOUT);
  localparam int unsigned StableW = cnt_width(LOCK_STABLE);
  localparam int unsigned RetryW  = $clog2(MAX_RETRIES + 1);

  pll_state_e          state_q, state_d;
  logic [RstW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [StableW-1:0]  stable_q, stable_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic                pll_rst_q, pll_rst_d;
  logic                clk_ready_q, clk_ready_d;
  logic                fault_q, fault_d;

  logic                locked_s;
  logic                timeout;

  sync_2ff u_lock_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  assign timeout = (timer_q == TimerW'(LOCK_TIMEOUT - 1));

  // State and counter registers; outputs are registered from the next state so
  // they change on the same edge as the state they describe.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= StResetPll;
      rst_cnt_q   <= '0;
      timer_q     <= '0;
      stable_q    <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      clk_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      timer_q     <= timer_d;
      stable_q    <= stable_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      clk_ready_q <= clk_ready_d;
      fault_q     <= fault_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    timer_d   = timer_q;
    stable_d  = stable_q;
    retry_d   = retry_q;

    unique case (state_q)
      StResetPll: begin
        timer_d = '0;
        if (rst_cnt_q == RstW'(RESET_CYCLES - 1)) begin
          rst_cnt_d = '0;
          state_d   = StWaitLock;
        end else begin
          rst_cnt_d = rst_cnt_q + RstW'(1);
        end
      end

      StWaitLock: begin
        timer_d = timer_q + TimerW'(1);
        // Timeout wins over a lock arriving on the same cycle.
        if (timeout) begin
          if (retry_q == RetryW'(MAX_RETRIES)) begin
            state_d = StFault;
          end else begin
            retry_d = retry_q + RetryW'(1);
            state_d = StResetPll;
          end
        end else if (locked_s) begin
          stable_d = '0;
          state_d  = StStabilize;
        end
      end

      StStabilize: begin
        // Timer is deliberately not cleared on a bounce back to WAIT_LOCK so
        // a chattering lock still times out.
        timer_d = timer_q + TimerW'(1);
        if (timeout) begin
          if (retry_q == RetryW'(MAX_RETRIES)) begin
            state_d = StFault;
          end else begin
            retry_d = retry_q + RetryW'(1);
            state_d = StResetPll;
          end
        end else if (!locked_s) begin
          state_d = StWaitLock;
        end else if (stable_q == StableW'(LOCK_STABLE - 1)) begin
          state_d = StReady;
        end else begin
          stable_d = stable_q + StableW'(1);
        end
      end

      StReady: begin
        if (relock_req || !locked_s) begin
          retry_d = '0;
          state_d = StResetPll;
        end
      end

      StFault: begin
        if (relock_req) begin
          retry_d = '0;
          state_d = StResetPll;
        end
      end

      default: begin
        state_d = StResetPll;
      end
    endcase
  end

  // Output decode from the next state.
  always_comb begin
    pll_rst_d   = (state_d == StResetPll) || (state_d == StFault);
    clk_ready_d = (state_d == StReady);
    fault_d     = (state_d == StFault);
  end

  assign pll_rst     = pll_rst_q;
  assign clk_ready   = clk_ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
  assign state       = state_q;

`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [LossCountWidth-1:0] loss_q;
  logic                      loss_inc;

  // A relock request on the same cycle as a loss is treated as a relock only.
  assign loss_inc = (state_q == StReady) && !locked_s && !relock_req;

  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_q <= '0;
    end else if (loss_inc && (loss_q != '1)) begin
      loss_q <= loss_q + LossCountWidth'(1);
    end
  end

  assign loss_count = loss_q;
`else
  assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with RESET_CYCLES=4, LOCK_TIMEOUT=100,
// LOCK_STABLE=8, MAX_RETRIES=2. Inputs change and outputs are sampled 1 ns
// after each rising edge.
module tb_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       clk_ready;
  logic       fault;
  logic [1:0] retry_count;
  logic [2:0] state;
  logic [7:0] loss_count;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef PLL_SEQ_LOSS_COUNT_EN
  localparam int unsigned LossAfterOne = 1;
`else
  localparam int unsigned LossAfterOne = 0;
`endif

  pll_lock_sequencer #(
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (100),
    .LOCK_STABLE  (8),
    .MAX_RETRIES  (2)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .relock_req  (relock_req),
    .pll_rst     (pll_rst),
    .clk_ready   (clk_ready),
    .fault       (fault),
    .retry_count (retry_count),
    .state       (state),
    .loss_count  (loss_count)
  );

  always #5 refclk = ~refclk;

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_pll_rst"}, 32'(pll_rst), 1);
    check({tag, "_clk_ready"}, 32'(clk_ready), 0);
    check({tag, "_fault"}, 32'(fault), 0);
    check({tag, "_retry"}, 32'(retry_count), 0);
    check({tag, "_loss"}, 32'(loss_count), 0);
  endtask

  initial begin
    int saw_ready;
    int bounces;
    logic [2:0] prev_state;

    rst        = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    tick(3);
    check_reset_values("reset");

    // Clean lock: pll_rst high for 4 edges, lock applied 10 cycles later.
    rst = 1'b0;
    tick(3);
    check("clean_rst_held", 32'(pll_rst), 1);
    check("clean_state_rp", 32'(state), 0);
    tick(1);
    check("clean_rst_fall", 32'(pll_rst), 0);
    check("clean_state_wl", 32'(state), 1);
    tick(10);
    pll_locked = 1'b1;
    tick(10);
    check("clean_not_ready_yet", 32'(clk_ready), 0);
    check("clean_state_stab", 32'(state), 2);
    tick(1);
    check("clean_ready", 32'(clk_ready), 1);
    check("clean_state_ready", 32'(state), 3);
    check("clean_retry", 32'(retry_count), 0);

    // One-cycle lock drop in READY.
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    check("loss_ready_l2", 32'(clk_ready), 1);
    tick(1);
    check("loss_ready_l3", 32'(clk_ready), 0);
    check("loss_pll_rst", 32'(pll_rst), 1);
    check("loss_state", 32'(state), 0);
    check("loss_count1", 32'(loss_count), LossAfterOne);
    tick(4);
    check("relock_rst_fall", 32'(pll_rst), 0);
    tick(8);
    check("relock_not_ready", 32'(clk_ready), 0);
    tick(1);
    check("relock_ready", 32'(clk_ready), 1);

    // Relock request coincides with a loss: no loss counted.
    pll_locked = 1'b0;
    tick(2);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    check("simul_state", 32'(state), 0);
    check("simul_clk_ready", 32'(clk_ready), 0);
    check("simul_loss", 32'(loss_count), LossAfterOne);
    check("simul_retry", 32'(retry_count), 0);

    // Reset asserted mid-STABILIZE.
    pll_locked = 1'b1;
    tick(5);
    check("midstab_state", 32'(state), 2);
    rst = 1'b1;
    tick(1);
    check_reset_values("midstab_rst");
    rst        = 1'b0;
    pll_locked = 1'b0;

    // Chatter: lock toggles every 5 cycles, attempt times out after 100 cycles.
    tick(4);
    check("chat_state_wl", 32'(state), 1);
    saw_ready  = 0;
    bounces    = 0;
    prev_state = state;
    for (int i = 0; i < 100; i++) begin
      pll_locked = ((i / 5) % 2) == 1;
      tick(1);
      if (clk_ready) saw_ready = 1;
      if (prev_state == 3'd2 && state == 3'd1) bounces++;
      prev_state = state;
    end
    check("chat_never_ready", 32'(saw_ready), 0);
    check("chat_bounced", 32'(bounces > 0), 1);
    check("chat_timeout_state", 32'(state), 0);
    check("chat_retry", 32'(retry_count), 1);

    // Never lock: three 104-cycle attempts, then FAULT.
    rst        = 1'b1;
    pll_locked = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(103);
    check("never_a0_end_state", 32'(state), 1);
    check("never_a0_retry", 32'(retry_count), 0);
    tick(1);
    check("never_a1_state", 32'(state), 0);
    check("never_a1_retry", 32'(retry_count), 1);
    check("never_a1_pll_rst", 32'(pll_rst), 1);
    tick(6);
    relock_req = 1'b1;  // ignored outside READY / FAULT
    tick(1);
    relock_req = 1'b0;
    check("never_relock_ignored", 32'(state), 1);
    check("never_relock_ign_retry", 32'(retry_count), 1);
    tick(97);
    check("never_a2_state", 32'(state), 0);
    check("never_a2_retry", 32'(retry_count), 2);
    tick(103);
    check("never_pre_fault_state", 32'(state), 1);
    check("never_pre_fault", 32'(fault), 0);
    tick(1);
    check("never_fault_state", 32'(state), 4);
    check("never_fault", 32'(fault), 1);
    check("never_fault_pll_rst", 32'(pll_rst), 1);
    check("never_fault_retry", 32'(retry_count), 2);
    tick(10);
    check("never_fault_held", 32'(state), 4);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    check("fault_relock_state", 32'(state), 0);
    check("fault_relock_fault", 32'(fault), 0);
    check("fault_relock_retry", 32'(retry_count), 0);
    check("fault_relock_pll_rst", 32'(pll_rst), 1);
    tick(4);
    check("fault_relock_rst_fall", 32'(pll_rst), 0);
    check("fault_relock_wl", 32'(state), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
